// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/decode/execute controller sitting in front of the 16-bit accumulator ALU.
// Owns acc, pc, ir and the operand latch, and shares one req/ack port for instructions and data.
module acc_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] acc_data,
    output logic [15:0] mem_data,
    output logic [15:0] arg_data,
    output logic        ctl_nad,
    output logic        ctl_shr,
    output logic        ctl_shl,
    output logic        ctl_lda,
    input  logic [15:0] alu_result,
    input  logic        alu_is_zero,
    output logic [11:0] pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_NAD = 4'h1;
    localparam logic [3:0] OP_SHR = 4'h2;
    localparam logic [3:0] OP_SHL = 4'h3;
    localparam logic [3:0] OP_LDM = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      state;
    state_t      state_d;
    logic [15:0] ir;
    logic [15:0] ir_d;
    logic [15:0] acc_d;
    logic [15:0] opnd_d;
    logic [11:0] pc_d;
    logic        fault_d;
    logic        boot;
    logic [3:0]  opcode;
    logic [11:0] operand_addr;

    assign opcode       = ir[15:12];
    assign operand_addr = ir[11:0];
    assign arg_data     = {4'h0, operand_addr};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        acc_d     = acc_data;
        pc_d      = pc;
        ir_d      = ir;
        opnd_d    = mem_data;
        fault_d   = fault;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = 16'h0000;
        ctl_nad   = 1'b0;
        ctl_shr   = 1'b0;
        ctl_shl   = 1'b0;
        ctl_lda   = 1'b0;
        halted    = 1'b0;

        case (state)
            S_FETCH: begin
                // The cycle right after reset stays quiet so a pending ack cannot be consumed.
                mem_req  = ~boot;
                mem_addr = pc;
                if (mem_req && mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc + 12'd1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP: state_d = S_FETCH;
                    OP_LDI: acc_d = arg_data;
                    OP_JMP: pc_d = operand_addr;
                    OP_JZ: begin
                        if (alu_is_zero) begin
                            pc_d = operand_addr;
                        end
                    end
                    OP_NAD, OP_LDM: state_d = S_OPERAND;
                    OP_SHR, OP_SHL: state_d = S_EXEC;
                    OP_STA: state_d = S_STORE;
                    OP_HLT: state_d = S_HALT;
                    default: begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end

            S_OPERAND: begin
                mem_req  = 1'b1;
                mem_addr = operand_addr;
                if (mem_ack) begin
                    if (opcode == OP_NAD) begin
                        opnd_d  = mem_rdata;
                        state_d = S_EXEC;
                    end else begin
                        acc_d   = mem_rdata;
                        state_d = S_FETCH;
                    end
                end
            end

            S_EXEC: begin
                ctl_nad = (opcode == OP_NAD);
                ctl_shr = (opcode == OP_SHR);
                ctl_shl = (opcode == OP_SHL);
                acc_d   = alu_result;
                state_d = S_FETCH;
            end

            S_STORE: begin
                // ALU passes acc through on ctl_lda, so the write data is the accumulator.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = operand_addr;
                ctl_lda   = 1'b1;
                mem_wdata = alu_result;
                if (mem_ack) begin
                    state_d = S_FETCH;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            acc_data <= 16'h0000;
            mem_data <= 16'h0000;
            ir       <= 16'h0000;
            pc       <= RESET_PC;
            fault    <= 1'b0;
            boot     <= 1'b1;
        end else begin
            state    <= state_d;
            acc_data <= acc_d;
            mem_data <= opnd_d;
            ir       <= ir_d;
            pc       <= pc_d;
            fault    <= fault_d;
            boot     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: behavioural ALU and memory with programmable ack waits,
// a store scoreboard, a table of small programs and hand-written multi-cycle sequences.
module tb_acc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [15:0] acc_data;
    logic [15:0] mem_data;
    logic [15:0] arg_data;
    logic        ctl_nad;
    logic        ctl_shr;
    logic        ctl_shl;
    logic        ctl_lda;
    logic [15:0] alu_result;
    logic        alu_is_zero;
    logic [11:0] pc;
    logic        halted;
    logic        fault;

    acc_sequencer #(.RESET_PC(12'h000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .acc_data   (acc_data),
        .mem_data   (mem_data),
        .arg_data   (arg_data),
        .ctl_nad    (ctl_nad),
        .ctl_shr    (ctl_shr),
        .ctl_shl    (ctl_shl),
        .ctl_lda    (ctl_lda),
        .alu_result (alu_result),
        .alu_is_zero(alu_is_zero),
        .pc         (pc),
        .halted     (halted),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Reference ALU: pass-through unless one strobe selects an operation.
    assign alu_result  = ctl_nad ? ~(acc_data & mem_data) :
                         ctl_shr ? (acc_data >> 1) :
                         ctl_shl ? (acc_data << 1) : acc_data;
    assign alu_is_zero = (acc_data == 16'h0000);

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } store_t;

    typedef struct packed {
        logic [63:0]      name;
        logic [0:5][15:0] prog;
        logic [11:0]      d_addr;
        logic [15:0]      d_val;
        logic [3:0]       wait_cyc;
        logic             st_en;
        logic [11:0]      st_addr;
        logic [15:0]      st_val;
        logic [15:0]      exp_acc;
        logic [11:0]      exp_pc;
        logic             exp_fault;
        logic [7:0]       exp_cycles;
        logic [3:0]       exp_nad;
    } vec_t;

    logic [15:0] mem [4096];
    store_t      sb_q[$];
    vec_t        vecs [8];

    int  checks = 0;
    int  errors = 0;
    int  wait_cfg = 0;
    int  wcnt = 0;
    int  nad_cycles = 0;
    int  req_cycles = 0;
    bit  ack_force = 1'b0;
    bit  ack_now;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_we = 1'b0;
    logic [11:0] prev_addr = 12'h000;
    logic [15:0] prev_wdata = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder and bus monitor; acks are driven mid-cycle and seen at the next rising edge.
    always @(negedge clk) begin
        if (prev_req && !prev_ack && mem_req) begin
            check("hold_addr", 32'(mem_addr), 32'(prev_addr));
            check("hold_we", 32'(mem_we), 32'(prev_we));
            check("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
        end
        check("ctl_onehot", 32'($countones({ctl_nad, ctl_shr, ctl_shl, ctl_lda}) <= 1), 32'd1);
        if (ctl_nad) nad_cycles++;
        if (mem_req) req_cycles++;

        ack_now = ack_force || (mem_req && (wcnt >= wait_cfg));
        if (mem_req && !ack_now) wcnt++;
        else wcnt = 0;
        mem_rdata = mem[mem_addr];
        if (mem_req && mem_we && ack_now) begin
            mem[mem_addr] = mem_wdata;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL store_unexpected: got addr=%0h data=%0h expected no store", mem_addr, mem_wdata);
            end else begin
                store_t s;
                s = sb_q.pop_front();
                check("store_addr", 32'(mem_addr), 32'(s.addr));
                check("store_data", 32'(mem_wdata), 32'(s.data));
            end
        end
        mem_ack    = ack_now;
        prev_req   = mem_req;
        prev_ack   = ack_now;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    function automatic vec_t mk(
        input logic [63:0] name,
        input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
        input logic [15:0] p3, input logic [15:0] p4, input logic [15:0] p5,
        input logic [11:0] d_addr, input logic [15:0] d_val, input logic [3:0] w,
        input logic st_en, input logic [11:0] st_addr, input logic [15:0] st_val,
        input logic [15:0] e_acc, input logic [11:0] e_pc, input logic e_fault,
        input logic [7:0] e_cyc, input logic [3:0] e_nad);
        vec_t v;
        v.name = name;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2;
        v.prog[3] = p3; v.prog[4] = p4; v.prog[5] = p5;
        v.d_addr = d_addr; v.d_val = d_val; v.wait_cyc = w;
        v.st_en = st_en; v.st_addr = st_addr; v.st_val = st_val;
        v.exp_acc = e_acc; v.exp_pc = e_pc; v.exp_fault = e_fault;
        v.exp_cycles = e_cyc; v.exp_nad = e_nad;
        return v;
    endfunction

    // Enter reset with a cleared memory; the caller loads the program in the same cycle.
    task automatic begin_reset(input int w);
        @(negedge clk);
        rst = 1'b1;
        ack_force = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        wait_cfg = w;
        nad_cycles = 0;
    endtask

    // Leaves the caller at the negedge of the first cycle after reset (first FETCH cycle).
    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cycles;
        begin_reset(int'(v.wait_cyc));
        for (int i = 0; i < 6; i++) mem[i] = v.prog[i];
        mem[v.d_addr] = v.d_val;
        if (v.st_en) sb_q.push_back('{addr: v.st_addr, data: v.st_val});
        release_reset();
        wait_halt(cycles);
        check($sformatf("%s_halted", v.name), 32'(halted), 32'd1);
        check($sformatf("%s_cycles", v.name), 32'(cycles), 32'(v.exp_cycles));
        check($sformatf("%s_acc", v.name), 32'(acc_data), 32'(v.exp_acc));
        check($sformatf("%s_pc", v.name), 32'(pc), 32'(v.exp_pc));
        check($sformatf("%s_fault", v.name), 32'(fault), 32'(v.exp_fault));
        check($sformatf("%s_nad", v.name), 32'(nad_cycles), 32'(v.exp_nad));
        check($sformatf("%s_sb_left", v.name), 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int cycles;

        //            name        prog words                                                 d_addr   d_val     w  st  st_addr  st_val    acc       pc       f  cyc nad
        vecs[0] = mk("ldishl",   16'h80F0, 16'h3000, 16'h5100, 16'hF000, 16'h0000, 16'h0000, 12'h800, 16'h0000, 0, 1, 12'h100, 16'h01E0, 16'h01E0, 12'h004, 0, 10, 0);
        vecs[1] = mk("nad",      16'h80FF, 16'h1200, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 12'h200, 16'h0F0F, 0, 0, 12'h000, 16'h0000, 16'hFFF0, 12'h003, 0, 8,  1);
        vecs[2] = mk("waitldm",  16'h4010, 16'h2000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 12'h010, 16'h8001, 3, 0, 12'h000, 16'h0000, 16'h4000, 12'h003, 0, 20, 0);
        vecs[3] = mk("jztaken",  16'h8000, 16'h7020, 16'hA000, 16'h0000, 16'h0000, 16'h0000, 12'h020, 16'hF000, 0, 0, 12'h000, 16'h0000, 16'h0000, 12'h021, 0, 6,  0);
        vecs[4] = mk("jznot",    16'h8001, 16'h7000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 12'h800, 16'h0000, 0, 0, 12'h000, 16'h0000, 16'h0001, 12'h003, 0, 6,  0);
        vecs[5] = mk("jmpwrap",  16'h6FFF, 16'hA000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 12'hFFF, 16'h6002, 0, 0, 12'h000, 16'h0000, 16'h0000, 12'h003, 0, 6,  0);
        vecs[6] = mk("illegal",  16'hA123, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 12'h800, 16'h0000, 0, 0, 12'h000, 16'h0000, 16'h0000, 12'h001, 1, 2,  0);
        vecs[7] = mk("mixwait",  16'h0000, 16'h85A5, 16'h2000, 16'h5101, 16'hF000, 16'h0000, 12'h800, 16'h0000, 1, 1, 12'h101, 16'h02D2, 16'h02D2, 12'h005, 0, 18, 0);

        // Reset held with ack asserted: bus stays idle, first fetch is at 000 right after release.
        @(negedge clk);
        rst = 1'b1;
        ack_force = 1'b1;
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", 32'(mem_req), 32'd0);
        end
        check("rst_pc", 32'(pc), 32'h000);
        check("rst_acc", 32'(acc_data), 32'h0000);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_ctl", 32'({ctl_nad, ctl_shr, ctl_shl, ctl_lda}), 32'd0);
        rst = 1'b0;
        ack_force = 1'b0;
        @(negedge clk);
        check("boot_req", 32'(mem_req), 32'd1);
        check("boot_addr", 32'(mem_addr), 32'h000);
        check("boot_we", 32'(mem_we), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // PC wrap: the fetch at FFF increments pc to 000 before DECODE loads the jump target.
        begin_reset(0);
        mem[12'h000] = 16'h6FFF;
        mem[12'hFFF] = 16'h6002;
        mem[12'h002] = 16'hF000;
        release_reset();
        check("wrap_first_addr", 32'(mem_addr), 32'h000);
        repeat (2) @(negedge clk);
        check("wrap_fetch_req", 32'(mem_req), 32'd1);
        check("wrap_fetch_addr", 32'(mem_addr), 32'hFFF);
        @(negedge clk);
        check("wrap_decode_pc", 32'(pc), 32'h000);
        @(negedge clk);
        check("wrap_target_addr", 32'(mem_addr), 32'h002);

        // Illegal opcode stops the bus for good; a reset then clears fault.
        begin_reset(0);
        mem[12'h000] = 16'hA123;
        release_reset();
        wait_halt(cycles);
        check("ill_fault", 32'(fault), 32'd1);
        req_cycles = 0;
        repeat (10) @(negedge clk);
        check("ill_quiet", 32'(req_cycles), 32'd0);
        check("ill_still_halted", 32'(halted), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstclr_fault", 32'(fault), 32'd0);
        check("rstclr_halted", 32'(halted), 32'd0);
        check("rstclr_req", 32'(mem_req), 32'd0);

        // Reset while a fetch is waiting on ack: the transaction is dropped and redone.
        mem[12'h000] = 16'h8123;
        mem[12'h001] = 16'hF000;
        wait_cfg = 5;
        rst = 1'b0;
        @(negedge clk);
        check("mf_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mf_req_drop", 32'(mem_req), 32'd0);
        check("mf_pc", 32'(pc), 32'h000);
        rst = 1'b0;
        @(negedge clk);
        check("mf_refetch_addr", 32'(mem_addr), 32'h000);
        wait_halt(cycles);
        check("mf_acc", 32'(acc_data), 32'h0123);
        check("mf_pc_end", 32'(pc), 32'h002);
        check("mf_fault", 32'(fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
